// File: rtl/cnu_stream.sv
// Streaming min-sum check-node unit: accumulates q beats of one check node, then emits r beats.
// Optional macro CNU_OFFSET_EN adds parameter OFFSET for offset min-sum magnitude correction.
module cnu_stream #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8,
  parameter int DMAX   = 32,
  parameter int NORM   = 1
`ifdef CNU_OFFSET_EN
  ,
  parameter int OFFSET = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] r,
  output logic [IDX_W-1:0]  out_idx
);

  localparam int unsigned CNT_W = $clog2(DMAX + 1);
  localparam int unsigned SEL_W = $clog2(DMAX);
  localparam int unsigned EXT_W = DATA_W + 2;
  localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAG_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;

  logic [0:0]        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0]  deg, deg_n;
  logic [CNT_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] min1, min1_n;
  logic [DATA_W-1:0] min2, min2_n;
  logic [CNT_W-1:0]  min_idx, min_idx_n;
  logic              rsgn, rsgn_n;
  logic [DMAX-1:0]   sgn, sgn_n;
  logic              in_ready_n;
  logic              out_valid_n;
  logic              out_last_n;
  logic [DATA_W-1:0] r_n;
  logic [IDX_W-1:0]  out_idx_n;
  logic [DATA_W-1:0] q_mag;

  // Normalised (and optionally offset) magnitude; widened so 3*m cannot overflow.
  function automatic logic [DATA_W-1:0] scale_mag(input logic [DATA_W-1:0] m);
    logic [EXT_W-1:0]  e;
    logic [EXT_W-1:0]  s;
    logic [DATA_W-1:0] res;
    e = EXT_W'(m);
    if (NORM == 1)      s = (e + (e << 1)) >> 2;
    else if (NORM == 2) s = e >> 1;
    else                s = e;
    res = DATA_W'(s);
`ifdef CNU_OFFSET_EN
    res = (res > DATA_W'(OFFSET)) ? res - DATA_W'(OFFSET) : '0;
`endif
    return res;
  endfunction

  // Outgoing message for edge i: excluded-self minimum, sign = parity of the other edges.
  function automatic logic [DATA_W-1:0] r_value(
    input logic [CNT_W-1:0]  i,
    input logic [DATA_W-1:0] m1,
    input logic [DATA_W-1:0] m2,
    input logic [CNT_W-1:0]  mi,
    input logic              neg
  );
    logic [DATA_W-1:0] mag;
    mag = scale_mag((i == mi) ? m2 : m1);
    return neg ? DATA_W'(0) - mag : mag;
  endfunction

  // Saturating magnitude: the most negative code maps to the largest positive one.
  always_comb begin
    if (q == MAG_NEG)        q_mag = MAG_MAX;
    else if (q[DATA_W-1])    q_mag = DATA_W'(0) - q;
    else                     q_mag = q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      deg       <= '0;
      idx       <= '0;
      min1      <= MAG_MAX;
      min2      <= MAG_MAX;
      min_idx   <= '0;
      rsgn      <= 1'b0;
      sgn       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      r         <= '0;
      out_idx   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      deg       <= deg_n;
      idx       <= idx_n;
      min1      <= min1_n;
      min2      <= min2_n;
      min_idx   <= min_idx_n;
      rsgn      <= rsgn_n;
      sgn       <= sgn_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      r         <= r_n;
      out_idx   <= out_idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    deg_n       = deg;
    idx_n       = idx;
    min1_n      = min1;
    min2_n      = min2;
    min_idx_n   = min_idx;
    rsgn_n      = rsgn;
    sgn_n       = sgn;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    r_n         = r;
    out_idx_n   = out_idx;

    case (state)
      ACCUM: begin
        if (in_valid && in_ready) begin
          sgn_n[cnt[SEL_W-1:0]] = q[DATA_W-1];
          rsgn_n = rsgn ^ q[DATA_W-1];
          if (q_mag < min1) begin
            min2_n    = min1;
            min1_n    = q_mag;
            min_idx_n = cnt;
          end else if (q_mag < min2) begin
            min2_n = q_mag;
          end
          cnt_n = cnt + CNT_W'(1);
          // First r beat is registered here so it appears the cycle after the last q.
          if (in_last || (cnt_n == CNT_W'(DMAX))) begin
            state_n     = EMIT;
            deg_n       = cnt_n;
            idx_n       = '0;
            in_ready_n  = 1'b0;
            out_valid_n = 1'b1;
            out_last_n  = (cnt_n == CNT_W'(1));
            out_idx_n   = '0;
            r_n         = r_value('0, min1_n, min2_n, min_idx_n, rsgn_n ^ sgn_n[0]);
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_n     = ACCUM;
            cnt_n       = '0;
            idx_n       = '0;
            min1_n      = MAG_MAX;
            min2_n      = MAG_MAX;
            min_idx_n   = '0;
            rsgn_n      = 1'b0;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            r_n         = '0;
            out_idx_n   = '0;
          end else begin
            idx_n      = idx + CNT_W'(1);
            out_idx_n  = IDX_W'(idx_n);
            out_last_n = (idx_n == deg - CNT_W'(1));
            r_n        = r_value(idx_n, min1, min2, min_idx, rsgn ^ sgn[idx_n[SEL_W-1:0]]);
          end
        end
      end
      default: state_n = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_cnu_stream.sv
// Scoreboard bench for cnu_stream: randomized nodes vs. an edge-by-edge min-sum reference.
module tb_cnu_stream;

  localparam int DW   = 8;
  localparam int IW   = 8;
  localparam int DM   = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] q;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [DW-1:0] r;
  logic [IW-1:0] out_idx;

  cnu_stream #(.DATA_W(DW), .IDX_W(IW), .DMAX(DM), .NORM(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .q(q),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .r(r), .out_idx(out_idx)
  );

  typedef struct packed {
    logic [DW-1:0] r;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    passes = 0;
  int    stall_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic int sat_mag(input int v);
    if (v < -127) return 127;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int scale(input int m);
    int s;
    s = (3 * m) / 4;
`ifdef CNU_OFFSET_EN
    s = (s > 1) ? s - 1 : 0;
`endif
    return s;
  endfunction

  // Reference: each edge sees the smallest magnitude and sign product of all other edges.
  task automatic push_expected(input int vals[DM], input int n);
    int    mag;
    int    smallest;
    bit    neg;
    int    rv;
    beat_t b;
    for (int i = 0; i < n; i++) begin
      smallest = 127;
      neg = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (j == i) continue;
        mag = sat_mag(vals[j]);
        if (mag < smallest) smallest = mag;
        if (vals[j] < 0) neg = ~neg;
      end
      rv = neg ? -scale(smallest) : scale(smallest);
      b.r = DW'(rv);
      b.idx = IW'(i);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_beat(input int v, input bit last);
    int t;
    in_valid = 1'b1;
    q = DW'(v);
    in_last = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic send_node(input int vals[DM], input int n, input bit use_last);
    push_expected(vals, n);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      drive_beat(vals[i], use_last && (i == n - 1));
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail_now("out_valid_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_r"}, 32'(r), 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
  endtask

  function automatic int rand_val();
    int pick;
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 255)) - 128;
      1: return int'($urandom_range(0, 8)) - 4;
      2: begin
        pick = int'($urandom_range(0, 3));
        return (pick == 0) ? -128 : (pick == 1) ? 127 : (pick == 2) ? -127 : 0;
      end
      default: return int'($urandom_range(0, 40)) - 20;
    endcase
  endfunction

  // Downstream back-pressure: random, or a forced run of stall cycles.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  initial begin : monitor
    beat_t         e;
    logic [17:0]   snap;
    bit            held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_stable", 32'({out_valid, out_last, out_idx, r}), 32'(snap));
        held = 1'b0;
      end
      if (out_valid) chk("in_ready_low_in_emit", 32'(in_ready), 32'd0);
      if (out_valid && !out_ready) begin
        held = 1'b1;
        snap = {out_valid, out_last, out_idx, r};
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          chk("r", 32'(r), 32'(e.r));
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int v[DM];
    int n;
    bit ul;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    q = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    send_node('{5, -3, 7, 2}, 4, 1'b1);
    send_node('{-128, 4, 0, 0}, 2, 1'b1);
    send_node('{3, 3, 9, 0}, 3, 1'b1);
    send_node('{-20, 0, 0, 0}, 1, 1'b1);
    // Full-degree node without in_last; next node's first beat waits through EMIT.
    send_node('{1, 2, 3, 4}, 4, 1'b0);
    send_node('{-7, 6, 0, 0}, 2, 1'b1);
    drain();

    send_node('{12, -40, 33, 8}, 4, 1'b1);
    wait_out_valid();
    stall_cnt = 3;
    drain();

    // Reset during emission.
    send_node('{9, -1, 5, -6}, 4, 1'b1);
    wait_out_valid();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_idle("rst_emit");
    send_node('{-2, 10, -11, 0}, 3, 1'b1);
    drain();

    // Reset during accumulation.
    drive_beat(10, 1'b0);
    drive_beat(-20, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("rst_accum");
    send_node('{6, -9, 0, 0}, 2, 1'b1);

    for (int k = 0; k < 60; k++) begin
      n = int'($urandom_range(1, DM));
      for (int i = 0; i < DM; i++) v[i] = rand_val();
      ul = (n < DM) ? 1'b1 : 1'(($urandom_range(0, 1)));
      send_node(v, n, ul);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
